// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator issuing {we, addr} + DSZ-bit register frames
module spi_master #(
  parameter int DSZ     = 96,
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           we,
  input  logic [6:0]     addr,
  input  logic [DSZ-1:0] wdat,
  output logic [DSZ-1:0] rdat,
  output logic           busy,
  output logic           done,
  output logic           spi_clk,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic           spi_ss
);

  localparam int N  = 8 + DSZ;
  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(2 * CLK_DIV);

  localparam logic [DW-1:0] H_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] G_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] N_LAST = BW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t         state;
  logic [DW-1:0]  div;
  logic [BW-1:0]  bit_cnt;
  logic [N-2:0]   sreg;
  logic [DSZ-1:0] cap;
  logic           we_q;
  logic           miso_m;
  logic           miso_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= spi_miso;
      miso_s <= miso_m;
    end
  end

  // sreg holds the bits still to go after the one on spi_mosi; cap keeps only
  // the last DSZ bits, so the command-byte bits fall off the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      cap      <= '0;
      we_q     <= 1'b0;
      rdat     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_ss   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            sreg     <= {addr, wdat};
            we_q     <= we;
            spi_mosi <= we;
            spi_ss   <= 1'b0;
            busy     <= 1'b1;
            div      <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (div == H_LAST) begin
            div     <= '0;
            spi_clk <= ~spi_clk;
            if (spi_clk) begin
              sreg    <= {sreg[N-3:0], 1'b0};
              cap     <= {cap[DSZ-2:0], miso_s};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == N_LAST) begin
                state    <= HOLD;
                spi_mosi <= 1'b0;
              end else begin
                spi_mosi <= sreg[N-2];
              end
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        HOLD: begin
          if (div == H_LAST) begin
            div    <= '0;
            state  <= GAP;
            spi_ss <= 1'b1;
            done   <= 1'b1;
            if (!we_q) rdat <= cap;
          end else begin
            div <= div + DW'(1);
          end
        end
        GAP: begin
          if (div == G_LAST) begin
            div   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            div <= div + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator that issues register read/write frames to the board's `spi_slave` register interface, so FPGA-side logic or a test harness can drive the register map instead of the Raspberry Pi. A frame consists of one command byte `{we, addr[6:0]}` followed by DSZ data bits. Both are MSB first, in SPI mode 0 with an active-low select. It sits in the `clk_32m` domain and drives `spi_clk` / `spi_mosi` / `spi_ss`, and samples `spi_miso`.

## Interface
- `DSZ`, default 96: data field width in bits. Matches the slave's `dsz`, which is 8*12.
- `CLK_DIV`, default 4: half-period of `spi_clk` in `clk` cycles. The minimum legal value is 3.
- `clk`  input  1  system clock (`clk_32m`).
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request. Accepted only when `busy`=0.
- `we`  input  1  1 = write frame, 0 = read frame. Latched on `start`.
- `addr`  input  7  register address. Latched on `start`.
- `wdat`  input  DSZ  write data. Latched on `start`; don't-care for reads.
- `rdat`  output  DSZ  data captured from MISO on the last read frame.
- `busy`  output  1  high while a frame or the deselect gap is in progress.
- `done`  output  1  one-cycle pulse at frame end.
- `spi_clk`  output  1  SPI clock. Idles low.
- `spi_mosi`  output  1  master-out data.
- `spi_miso`  input  1  slave-out data, asynchronous to `clk`.
- `spi_ss`  output  1  slave select, active low.

## Operation
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - `spi_ss`=1, `spi_clk`=0, `spi_mosi`=0
  - `busy`=0, `done`=0, `rdat`=0
  - FSM returns to IDLE, and the divider and bit counter clear.
- `spi_miso` passes through a 2-flop synchronizer (clocked by `clk`, reset by `reset`) before use.
- Frame length N = 8 + DSZ bits. The shift-out register is loaded on `start` with `{we, addr, wdat}`.
- FSM states:
  - IDLE:
    - `start`=1 → SHIFT; latch the inputs and set `busy`=1.
    - `start`=0 → stay in IDLE.
  - SHIFT:
    - `spi_ss`=0.
    - `spi_clk` toggles every CLK_DIV cycles, beginning low.
    - `spi_mosi` presents the current MSB while `spi_clk` is low. It shifts to the next bit on each falling edge.
    - The synchronized MISO bit is shifted into the capture register in the cycle of each falling edge, including the final one.
    - After the N-th falling edge → HOLD.
  - HOLD: `spi_clk`=0 and `spi_ss`=0 for CLK_DIV cycles → GAP.
  - GAP:
    - On entry:
      - `spi_ss`=1 and `done`=1 for one cycle.
      - For a read frame, `rdat` ← the low DSZ bits of the capture register.
      - A write frame leaves `rdat` unchanged.
    - Stay for 2*CLK_DIV cycles, then go to IDLE with `busy`=0.
- `start` while `busy`=1 is ignored, with no queuing and no effect on the current frame.
- Capture register: N bits shifted in MSB first. Bits captured during the command byte are discarded, and `rdat` takes bits DSZ-1..0.
- The bit counter is sized for N (ceil(log2(N+1)) bits) and never wraps within a frame.
- `spi_mosi` returns to 0 in HOLD, GAP and IDLE.

## Timing
- Let t0 be the cycle in which `start` is sampled high in IDLE, and H = CLK_DIV.
- t0+1:
  - `spi_ss`=0, `busy`=1, `spi_mosi`=`we`, `spi_clk`=0.
- Rising edges of `spi_clk` occur at t0+1+H*(2k+1), for k = 0..N-1.
- Falling edges occur at t0+1+H*(2k+2), for k = 0..N-1.
- MISO capture:
  - Bit k is sampled at falling edge k.
  - The slave shifts on falling edges, so the bit launched after rising edge k is stable H-2 cycles before the sample, given the 2-flop sync delay.
  - This requires H ≥ 3.
- At t0+1+(2N+1)H: `spi_ss`=1, `done`=1, and `rdat` is valid in the same cycle.
- At t0+1+(2N+3)H: `busy`=0. A `start` in this cycle is accepted.
- Minimum `spi_ss` high time between frames is 2H+1 cycles.
- Defaults (N=104, H=4): `done` at t0+837, `busy` low at t0+845.

## Test plan
- **Reset values:** assert `reset` with `clk` running → all outputs hold their reset values. Deassert, keep `start`=0 for 100 cycles → `spi_ss` stays 1 and `spi_clk` never toggles.
- **Write frame:** `start`, `we`=1, `addr`=0x7D, `wdat`=25000.
  - MOSI sampled on the 104 rising edges reads 0xFD, then 25000 as 96 bits MSB first.
  - `done` at t0+837; `rdat` unchanged.
- **Read frame:** MISO model returns 96'h0A5 after the command byte, with 0xFF during the command byte.
  - MOSI command byte reads 0x7E.
  - `rdat`=96'h0A5 coincident with `done`.
- **Busy handling:**
  - A `start` pulse at t0+50 is ignored: exactly one frame is produced and one `done` pulse.
  - A `start` in the first cycle with `busy`=0 begins the next frame, and `spi_ss` stays high for 2H+1=9 cycles between frames.
- **Mid-frame reset:** assert `reset` after the 40th rising edge.
  - `spi_ss`=1, `spi_clk`=0 and `busy`=0 in the same cycle, with no `done` pulse.
  - The next read frame is complete (104 edges) with correct `rdat`.
- **Loopback against `spi_slave` plus register logic, with H=4:**
  - Write 0x7D = 0x1234, then read 0x7D → `rdat`=0x1234.
  - Two reads of 0x7E return consecutive `read_count` values.
  - Assertion: `done` never rises while `reset` is high.
